// File: rtl/instr_encoder_if.sv
// Handshake and field bundle between a driver and the instruction encoder.
// The driver uses the master side; the encoder uses the slave side.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  op;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        restart;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic [31:0] addr;
   logic        err;
   logic [15:0] err_count;

   modport master (
      output in_valid, op, rd, rs1, rs2, funct3, funct7, imm, restart, out_ready,
      input  in_ready, out_valid, instr, addr, err, err_count
   );

   modport slave (
      input  in_valid, op, rd, rs1, rs2, funct3, funct7, imm, restart, out_ready,
      output in_ready, out_valid, instr, addr, err, err_count
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32 instruction fields into a 32-bit word behind a single-entry output
// register, tagging each word with a wrapping byte address; bad bundles become NOP.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic           clk,
   input  logic           reset,
   instr_encoder_if.slave bus
);
   localparam int unsigned     SLOT_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DEPTH_WORDS - 1);
   localparam logic [31:0]     NOP_WORD  = 32'h0000_0013;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   logic              out_valid_q, out_valid_d;
   logic [31:0]       instr_q, instr_d;
   logic              err_q, err_d;
   logic [31:0]       addr_q, addr_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [15:0]       err_count_q, err_count_d;

   logic        accept;
   logic        xfer;
   logic        is_shift;
   logic        fits12, fits13, fits21;
   logic [31:0] raw_word;
   logic        enc_bad;
   logic [31:0] enc_word;

   // An immediate fits N signed bits when all bits above N-1 match the sign bit.
   assign fits12   = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
   assign fits13   = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
   assign fits21   = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);
   assign is_shift = (bus.op == OP_IMM) && ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b101));

   always_comb begin
      raw_word = NOP_WORD;
      enc_bad  = 1'b0;
      case (bus.op)
         OP_REG: begin
            raw_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.op};
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            if (is_shift) begin
               raw_word = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, bus.op};
               enc_bad  = |bus.imm[31:5];
            end else begin
               raw_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.op};
               enc_bad  = ~fits12;
            end
         end
         OP_STORE: begin
            raw_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.op};
            enc_bad  = ~fits12;
         end
         OP_BRANCH: begin
            raw_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                        bus.imm[4:1], bus.imm[11], bus.op};
            enc_bad  = ~fits13 | bus.imm[0];
         end
         OP_JAL: begin
            raw_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.op};
            enc_bad  = ~fits21 | bus.imm[0];
         end
         OP_LUI, OP_AUIPC: begin
            raw_word = {bus.imm[31:12], bus.rd, bus.op};
            enc_bad  = |bus.imm[11:0];
         end
         default: begin
            raw_word = NOP_WORD;
            enc_bad  = 1'b1;
         end
      endcase
      enc_word = enc_bad ? NOP_WORD : raw_word;
   end

   assign bus.in_ready  = ~out_valid_q | bus.out_ready;
   assign accept        = bus.in_valid & bus.in_ready;
   assign xfer          = out_valid_q & bus.out_ready;

   assign bus.out_valid = out_valid_q;
   assign bus.instr     = instr_q;
   assign bus.err       = err_q;
   assign bus.addr      = addr_q;
   assign bus.err_count = err_count_q;

   // Restart beats the post-transfer increment; the held word is untouched by it.
   always_comb begin
      out_valid_d = out_valid_q;
      instr_d     = instr_q;
      err_d       = err_q;
      addr_d      = addr_q;
      slot_d      = slot_q;
      err_count_d = err_count_q;

      if (accept) begin
         out_valid_d = 1'b1;
         instr_d     = enc_word;
         err_d       = enc_bad;
      end else if (xfer) begin
         out_valid_d = 1'b0;
      end

      if (bus.restart) begin
         addr_d = BASE_ADDR;
         slot_d = '0;
      end else if (xfer) begin
         if (slot_q == LAST_SLOT) begin
            addr_d = BASE_ADDR;
            slot_d = '0;
         end else begin
            addr_d = addr_q + 32'd4;
            slot_d = slot_q + SLOT_W'(1);
         end
      end

      if (xfer && err_q && (err_count_q != 16'hFFFF)) begin
         err_count_d = err_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         instr_q     <= '0;
         err_q       <= 1'b0;
         addr_q      <= BASE_ADDR;
         slot_q      <= '0;
         err_count_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         err_q       <= err_d;
         addr_q      <= addr_d;
         slot_q      <= slot_d;
         err_count_q <= err_count_d;
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 4-slot address window at base 0.
module tb_instr_encoder;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_mis = 0;

   instr_encoder_if bus ();

   instr_encoder #(
      .BASE_ADDR   (32'h0000_0000),
      .DEPTH_WORDS (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [31:0] ins, input logic [31:0] adr,
                             input logic e);
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".instr"}, bus.instr, ins);
      check({tag, ".addr"}, bus.addr, adr);
      check({tag, ".err"}, 32'(bus.err), 32'(e));
   endtask

   task automatic present(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] imm);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.rd       = rd;
      bus.rs1      = rs1;
      bus.rs2      = rs2;
      bus.funct3   = f3;
      bus.funct7   = f7;
      bus.imm      = imm;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.op        = '0;
      bus.rd        = '0;
      bus.rs1       = '0;
      bus.rs2       = '0;
      bus.funct3    = '0;
      bus.funct7    = '0;
      bus.imm       = '0;
      bus.restart   = 1'b0;
      bus.out_ready = 1'b1;
      reset         = 1'b1;

      // reset state
      tick();
      tick();
      check("rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("rst.instr", bus.instr, 32'd0);
      check("rst.err", 32'(bus.err), 32'd0);
      check("rst.addr", bus.addr, 32'd0);
      check("rst.err_count", 32'(bus.err_count), 32'd0);
      reset = 1'b0;
      tick();
      check("rst.in_ready", 32'(bus.in_ready), 32'd1);

      // addi x1,x0,5 with one-cycle latency, then drain
      present(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      tick();
      check_word("addi", 32'h0050_0093, 32'h0, 1'b0);
      idle();
      tick();
      check("addi_drain.out_valid", 32'(bus.out_valid), 32'd0);
      check("addi_drain.addr", bus.addr, 32'h4);

      bus.restart = 1'b1;
      tick();
      bus.restart = 1'b0;
      check("restart_idle.addr", bus.addr, 32'h0);

      // back-to-back burst, then a fifth word landing on the wrapped address
      present(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
      tick();
      check_word("lui", 32'h1234_52B7, 32'h0, 1'b0);
      present(OP_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
      tick();
      check_word("sw", 32'h0020_A423, 32'h4, 1'b0);
      present(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd8);
      tick();
      check_word("beq", 32'h0020_8463, 32'h8, 1'b0);
      present(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
      tick();
      check_word("jal", 32'h0100_00EF, 32'hC, 1'b0);
      present(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      tick();
      check_word("wrap5", 32'h0050_0093, 32'h0, 1'b0);
      idle();
      tick();
      check("wrap_drain.out_valid", 32'(bus.out_valid), 32'd0);
      check("wrap_drain.addr", bus.addr, 32'h4);

      // downstream stall for three cycles with a second bundle waiting
      bus.out_ready = 1'b0;
      present(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      tick();
      check_word("stall_a", 32'h0050_0093, 32'h4, 1'b0);
      present(OP_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("stall%0d.instr", i), bus.instr, 32'h0050_0093);
         check($sformatf("stall%0d.addr", i), bus.addr, 32'h4);
         check($sformatf("stall%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      check_word("stall_b", 32'h0020_A423, 32'h8, 1'b0);
      idle();
      tick();
      check("stall_drain.out_valid", 32'(bus.out_valid), 32'd0);
      check("stall_drain.addr", bus.addr, 32'hC);

      // three rejected bundles become NOPs and are counted on transfer
      present(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
      tick();
      check_word("bad_addi", NOP_WORD, 32'hC, 1'b1);
      present(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3);
      tick();
      check_word("bad_beq", NOP_WORD, 32'h0, 1'b1);
      present(7'b1111111, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
      tick();
      check_word("bad_op", NOP_WORD, 32'h4, 1'b1);
      idle();
      tick();
      check("bad_drain.err_count", 32'(bus.err_count), 32'd3);
      check("bad_drain.addr", bus.addr, 32'h8);

      // range boundaries: shift form, most negative I imm, U with low bits set
      present(OP_IMM, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'd3);
      tick();
      check_word("slli", 32'h0030_9093, 32'h8, 1'b0);
      present(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
      tick();
      check_word("addi_min", 32'h8000_0093, 32'hC, 1'b0);
      present(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
      tick();
      check_word("bad_lui", NOP_WORD, 32'h0, 1'b1);
      idle();
      tick();
      check("edge_drain.err_count", 32'(bus.err_count), 32'd4);
      check("edge_drain.addr", bus.addr, 32'h4);

      // restart on a transfer cycle beats the increment
      present(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      tick();
      check_word("pre_restart", 32'h0050_0093, 32'h4, 1'b0);
      bus.restart = 1'b1;
      present(OP_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
      tick();
      bus.restart = 1'b0;
      check_word("restart_xfer", 32'h0020_A423, 32'h0, 1'b0);
      idle();
      tick();
      check("restart_drain.out_valid", 32'(bus.out_valid), 32'd0);
      check("restart_drain.addr", bus.addr, 32'h4);

      // reset while stalled discards the held word
      bus.out_ready = 1'b0;
      present(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      tick();
      check_word("pre_rst_stall", 32'h0050_0093, 32'h4, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      check("rst_stall.out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_stall.addr", bus.addr, 32'h0);
      check("rst_stall.err_count", 32'(bus.err_count), 32'd0);
      check("rst_stall.instr", bus.instr, 32'd0);
      reset = 1'b0;
      idle();
      bus.out_ready = 1'b1;
      tick();
      check("post_rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("post_rst.addr", bus.addr, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first emitted instruction word.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of word slots before the address wraps.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  field bundle presented.
REQ-006 in_ready  output  1  encoder accepts a bundle this cycle.
REQ-007 op/rd/rs1/rs2/funct3/funct7  input  7/5/5/5/3/7  instruction fields.
REQ-008 imm  input  32  signed immediate as a byte value; U-type carries the full upper value.
REQ-009 restart  input  1  returns the write address to BASE_ADDR.
REQ-010 out_valid  output  1  encoded word held.
REQ-011 out_ready  input  1  downstream (instruction-memory loader) takes the word.
REQ-012 instr  output  32  encoded instruction.
REQ-013 addr  output  32  byte address for instr.
REQ-014 err  output  1  held word was replaced by NOP.
REQ-015 err_count  output  16  saturating count of NOP substitutions.

Function
REQ-016 Format select from op: 0010011/0000011/1100111 = I; 0100011 = S; 1100011 = B; 1101111 = J; 0110111/0010111 = U; 0110011 = R; any other op is illegal.
REQ-017 R: {funct7,rs2,rs1,funct3,rd,op}.
REQ-018 I: {imm[11:0],rs1,funct3,rd,op}; for op 0010011 with funct3 001/101: {funct7,imm[4:0],rs1,funct3,rd,op}.
REQ-019 S: {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
REQ-020 B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}.
REQ-021 J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-022 U: {imm[31:12],rd,op}.
REQ-023 Range errors: I/S imm outside -2048..2047; shift imm outside 0..31; B imm outside -4096..4094 or odd; J imm outside -1048576..1048574 or odd; U imm[11:0] != 0.
REQ-024 On an illegal op or range error, SHALL emit 32'h0000_0013 with err=1; otherwise err=0.
REQ-025 Output register is single-entry; in_ready = !out_valid || out_ready, combinational.
REQ-026 Accept = in_valid && in_ready; accepted bundle appears on instr/err with out_valid=1 the next cycle (latency 1).
REQ-027 Full throughput: with out_ready held at 1, one word per cycle.
REQ-028 While out_valid && !out_ready: instr, addr and err held stable; no accept.
REQ-029 Transfer = out_valid && out_ready; on transfer, addr advances by 4, and after slot DEPTH_WORDS-1 it wraps to BASE_ADDR.
REQ-030 On transfer with no new accept, out_valid falls to 0 the next cycle.
REQ-031 restart=1: addr = BASE_ADDR next cycle and overrides any same-cycle increment; the held word and out_valid are unaffected.
REQ-032 err_count increments on each transfer with err=1 and saturates at 16'hFFFF.

Reset
REQ-033 reset=1 overrides all inputs: next cycle out_valid=0, instr=0, err=0, addr=BASE_ADDR, err_count=0; in_ready=1 once reset is low.
REQ-034 Reset during a stall discards the held word with no transfer.

Verification
REQ-035 The bench SHALL cover addi x1,x0,5 (op 0010011, rd=1, imm=5) -> instr 0x00500093, addr 0x0, err=0, one cycle after accept.
REQ-036 The bench SHALL cover a burst of lui x5,0x12345000; sw x2,8(x1); beq x1,x2,+8; jal x1,+16 with out_ready=1 -> 0x123452B7, 0x0020A423, 0x00208463, 0x010000EF on consecutive cycles at addr 0x0,0x4,0x8,0xC.
REQ-037 The bench SHALL cover out_ready=0 for 3 cycles with in_valid=1 -> instr/addr stable, in_ready=0, no word lost after release.
REQ-038 The bench SHALL cover addi with imm=4096, beq with imm=3, and op=1111111 -> three words of 0x00000013 with err=1, and err_count=3.
REQ-039 The bench SHALL cover DEPTH_WORDS=4 with 5 transfers -> 5th addr = BASE_ADDR, and restart asserted on a transfer cycle -> next addr = BASE_ADDR.
REQ-040 The bench SHALL cover reset asserted during a stall -> out_valid=0, addr=BASE_ADDR, err_count=0 next cycle.
